// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - oversampling UART receiver with runtime frame format and valid/ready output
module uart_rx_os #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_in,
    input  logic [DIV_WIDTH-1:0]  baud_div,
    input  logic                  parity_en,
    input  logic                  parity_odd,
    input  logic                  parity_per_byte,
    input  logic                  two_stop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid,
    input  logic                  ready,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int SW     = $clog2(OVERSAMPLE);
    localparam int BW     = $clog2(DATA_WIDTH + 1);
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int YW     = $clog2(NBYTES + 1);
    localparam logic [SW-1:0] SAMP_MID = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SAMP_END = SW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
    } state_t;

    state_t                state;
    logic                  rx_m, rx_s;
    logic [DIV_WIDTH-1:0]  div_cnt, baud_div_l;
    logic [SW-1:0]         samp_cnt;
    logic [BW-1:0]         bit_cnt, bit_next;
    logic [YW-1:0]         byte_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  par_run, par_acc, frame_acc;
    logic                  par_en_l, par_odd_l, per_byte_l, two_stop_l;
    logic                  tick, samp_hit, deliver, last_byte;

    assign tick      = (state != S_IDLE) && (div_cnt == baud_div_l);
    assign samp_hit  = tick && (samp_cnt == ((state == S_START) ? SAMP_MID : SAMP_END));
    assign deliver   = samp_hit && ((state == S_STOP1 && !two_stop_l) || state == S_STOP2);
    assign bit_next  = bit_cnt + 1'b1;
    assign last_byte = (byte_cnt == YW'(NBYTES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            rx_m       <= 1'b1;
            rx_s       <= 1'b1;
            div_cnt    <= '0;
            baud_div_l <= '0;
            samp_cnt   <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            shift_reg  <= '0;
            par_run    <= 1'b0;
            par_acc    <= 1'b0;
            frame_acc  <= 1'b0;
            par_en_l   <= 1'b0;
            par_odd_l  <= 1'b0;
            per_byte_l <= 1'b0;
            two_stop_l <= 1'b0;
            data_out   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rx_m <= rx_in;
            rx_s <= rx_m;

            if (valid && ready) begin
                valid   <= 1'b0;
                overrun <= 1'b0;
            end

            if (tick) begin
                div_cnt  <= '0;
                samp_cnt <= samp_hit ? '0 : samp_cnt + 1'b1;
            end else if (state != S_IDLE) begin
                div_cnt <= div_cnt + 1'b1;
            end

            case (state)
                S_IDLE: if (!rx_s) begin
                    state      <= S_START;
                    div_cnt    <= '0;
                    samp_cnt   <= '0;
                    bit_cnt    <= '0;
                    byte_cnt   <= '0;
                    shift_reg  <= '0;
                    par_run    <= 1'b0;
                    par_acc    <= 1'b0;
                    frame_acc  <= 1'b0;
                    baud_div_l <= baud_div;
                    par_en_l   <= parity_en;
                    par_odd_l  <= parity_odd;
                    per_byte_l <= parity_per_byte;
                    two_stop_l <= two_stop;
                end
                // A start bit that has gone high again by mid-bit is treated as noise
                S_START: if (samp_hit) state <= rx_s ? S_IDLE : S_DATA;
                S_DATA: if (samp_hit) begin
                    shift_reg <= {rx_s, shift_reg[DATA_WIDTH-1:1]};
                    par_run   <= par_run ^ rx_s;
                    bit_cnt   <= bit_next;
                    if (par_en_l && per_byte_l && bit_next[2:0] == 3'd0)
                        state <= S_PARITY;
                    else if (bit_next == BW'(DATA_WIDTH))
                        state <= par_en_l ? S_PARITY : S_STOP1;
                end
                S_PARITY: if (samp_hit) begin
                    if (rx_s != (par_run ^ par_odd_l))
                        par_acc <= 1'b1;
                    if (per_byte_l) begin
                        par_run  <= 1'b0;
                        byte_cnt <= byte_cnt + 1'b1;
                        state    <= last_byte ? S_STOP1 : S_DATA;
                    end else begin
                        state <= S_STOP1;
                    end
                end
                S_STOP1: if (samp_hit) begin
                    if (!rx_s)
                        frame_acc <= 1'b1;
                    state <= two_stop_l ? S_STOP2 : S_IDLE;
                end
                S_STOP2: if (samp_hit) begin
                    if (!rx_s)
                        frame_acc <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            // Delivery overrides a same-cycle handshake so back-to-back words keep valid high
            if (deliver) begin
                if (!valid || ready) begin
                    data_out   <= shift_reg;
                    parity_err <= par_acc;
                    frame_err  <= frame_acc | ~rx_s;
                    valid      <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Parametrised oversampling UART receiver, successor to the single-format receive FSM. Generalises word width and frame format: runtime baud divider, optional even/odd parity over the whole word or per byte, one or two stop bits. Adds mid-bit sampling, start-glitch rejection, framing and overrun detection, and a valid/ready output handshake. Sits between the pad-side `rx_in` synchroniser input and the receive FIFO/register interface.

## Interface
- `DATA_WIDTH`, 8: word width in bits; multiple of 8, range 8–64.
- `OVERSAMPLE`, 16: ticks per bit; even, ≥ 4.
- `DIV_WIDTH`, 16: width of `baud_div`.
- `clk` in 1: single clock.
- `rst_n` in 1: reset, synchronous and active-low.
- `rx_in` in 1: asynchronous serial line; idle high.
- `baud_div` in DIV_WIDTH: clocks per oversample tick minus 1.
- `parity_en` in 1: 1 = parity bit(s) present.
- `parity_odd` in 1: 1 = odd parity, 0 = even.
- `parity_per_byte` in 1: 1 = parity bit after every 8 data bits; 0 = one parity bit after the full word.
- `two_stop` in 1: 1 = two stop bits.
- `data_out` out DATA_WIDTH: received word, LSB first on the line.
- `valid` out 1: `data_out` and error flags valid.
- `ready` in 1: consumer accepts the word when `valid && ready`.
- `parity_err` out 1: at least one parity mismatch in this word.
- `frame_err` out 1: a stop bit sampled 0.
- `overrun` out 1: sticky; a word was lost while `valid` was held.

## Operation
- `rx_in` passes through a 2-flop synchroniser (`rx_s`). All decisions use `rx_s`.
- Tick generator:
  - Counts 0..`baud_div_l` and emits `tick` on the terminal count.
  - Restarts at 0 on start detection.
  - Runs only outside IDLE.
- Config inputs (`baud_div`, `parity_*`, `two_stop`) are latched on start detection. Changes mid-frame have no effect.
- FSM states are IDLE, START, DATA, PARITY, STOP1, STOP2.
  - **IDLE**: `rx_s==0` → START. Clear the sample counter, bit counter, byte counter, shift register and error accumulators.
  - **START**: at tick count OVERSAMPLE/2−1, if `rx_s==1` (glitch) → IDLE with no output. Otherwise reset the sample counter → DATA.
  - **DATA**: every OVERSAMPLE ticks (mid-bit), shift `rx_s` into the MSB of the shift register and XOR it into the running parity.
    - After 8 bits with `parity_en && parity_per_byte` → PARITY.
    - After DATA_WIDTH bits: → PARITY if `parity_en`, else → STOP1.
  - **PARITY**: mid-bit sample.
    - Mismatch when `rx_s != running_parity ^ parity_odd`; a mismatch sets the accumulated `parity_err`.
    - In per-byte mode the running parity then resets and the byte counter increments. If more bytes remain → DATA, else → STOP1.
  - **STOP1**: mid-bit sample; 0 sets `frame_err`. Then → STOP2 if `two_stop`, else deliver and → IDLE.
  - **STOP2**: same check, then deliver and → IDLE.
- **Deliver**:
  - If `valid==0` or `ready==1` in the same cycle: load `data_out`, `parity_err`, `frame_err`, and set `valid`.
  - Otherwise discard the word and set `overrun`.
- `valid` clears on `valid && ready` unless a delivery happens in that same cycle; delivery wins and `valid` stays 1.
- `overrun` clears on a `valid && ready` handshake.
- Per-byte mode requires DATA_WIDTH/8 parity bits; whole-word mode uses exactly one.
- The frame returns to IDLE at the mid-point of the last stop bit, giving half a bit of resync margin.

## Timing
- Reset (`rst_n==0` at a `clk` edge):
  - FSM → IDLE; all counters 0.
  - `data_out` = 0, `valid` = 0, `parity_err` = 0, `frame_err` = 0, `overrun` = 0; synchroniser flops reset to 1.
  - Reset mid-frame abandons the frame with no output.
- Bit period = OVERSAMPLE × (`baud_div`+1) clocks.
- Start detection occurs 2 clocks after the `rx_in` falling edge, because of the synchroniser.
- `valid` rises 1 clock after the mid-bit tick of the final stop bit.
- Glitch rejection: a low pulse shorter than OVERSAMPLE/2 ticks produces no word.
- Back-to-back frames with zero idle between them are received without loss. The next start edge may arrive while the FSM is still in IDLE.
- Handshake: the word is held stable while `valid && !ready`.

## Test plan
- Format 8N1, `baud_div`=0, OVERSAMPLE=16, byte 0xA5, `ready`=1 → `data_out`=0xA5, `valid` pulses 1 cycle, all flags 0. `valid` rises 2+16×9.5+1 clocks after the falling edge, within ±1.
- DATA_WIDTH=16, even parity per byte, bytes 0x34, 0x12 with correct parity bits → 0x1234, no errors. Repeat with the parity bit of the second byte flipped → 0x1234 with `parity_err`=1.
- Whole-word odd parity, 0x00 with parity bit 0 → `parity_err`=1. With parity bit 1 → `parity_err`=0.
- Format 8N2, 0x5A, second stop bit driven 0 → `frame_err`=1, `data_out`=0x5A.
- `ready`=0, send 0x11 then 0x22 back-to-back → `data_out` stays 0x11, `overrun`=1. Raise `ready` → handshake, then `valid`=0 and `overrun`=0.
- A 6-clock low glitch (`baud_div`=0) → no `valid`, FSM back in IDLE. Reset asserted mid-DATA → all outputs 0, and the next clean frame 0xC3 is received correctly.
